// File: rtl/uart_receive_frame.sv
// uart_receive_frame: 8N1 serial receiver that assembles FRAME_BYTES consecutive bytes
// into frame_buf, discarding partial frames on a framing error or inter-byte timeout.
module uart_receive_frame #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FRAME_BYTES  = 12,
    parameter int TIMEOUT_CLKS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        data_in,
    output logic [FRAME_BYTES-1:0][7:0] frame_buf,
    output logic                        frame_valid,
    output logic                        frame_err,
    output logic                        busy
);
    localparam int HALF   = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    logic                        r_sync1, r_sync2;
    logic                        w_rx;
    state_t                      r_state, w_state_next;
    logic [CNT_W-1:0]            r_clk_cnt;
    logic [2:0]                  r_bit_cnt;
    logic [7:0]                  r_shift;
    logic [FRAME_BYTES-1:0][7:0] r_staging;
    logic [FRAME_BYTES-1:0][7:0] w_frame_next;
    logic [3:0]                  r_byte_idx;
    logic [IDLE_W-1:0]           r_idle_cnt;
    logic                        w_bit_tick, w_last_byte;
    logic                        w_start_det, w_shift_en, w_byte_good, w_byte_bad, w_timeout;

    assign w_rx        = r_sync2;
    assign w_bit_tick  = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_last_byte = (r_byte_idx == 4'(FRAME_BYTES - 1));
    assign busy        = (r_state != S_IDLE) || (r_byte_idx != 4'd0);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
        end else begin
            r_sync1 <= data_in;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_start_det  = 1'b0;
        w_shift_en   = 1'b0;
        w_byte_good  = 1'b0;
        w_byte_bad   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A start edge takes priority over a timeout expiring on the same clk.
                if (!w_rx) begin
                    w_start_det  = 1'b1;
                    w_state_next = (HALF == 0) ? S_DATA : S_START;
                end else if (r_byte_idx != 4'd0 && r_idle_cnt == IDLE_W'(TIMEOUT_CLKS - 1)) begin
                    w_timeout = 1'b1;
                end
            end
            S_START: begin
                if (r_clk_cnt == CNT_W'(HALF)) w_state_next = w_rx ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_tick) begin
                    if (w_rx) begin
                        w_byte_good  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_byte_bad   = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_rx) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_frame_next                = r_staging;
        w_frame_next[FRAME_BYTES-1] = r_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_byte_idx  <= '0;
            r_idle_cnt  <= '0;
            frame_buf   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= w_byte_good && w_last_byte;
            frame_err   <= w_byte_bad || w_timeout;

            // START counts from 1 because the IDLE detect clk was start-bit sample 0.
            if (w_state_next != r_state)
                r_clk_cnt <= (w_state_next == S_START) ? CNT_W'(1) : '0;
            else if (w_bit_tick)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + 1'b1;

            if (w_start_det)     r_bit_cnt <= '0;
            else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_shift_en) r_shift <= {w_rx, r_shift[7:1]};

            if (w_byte_good) begin
                if (w_last_byte) begin
                    frame_buf  <= w_frame_next;
                    r_byte_idx <= '0;
                end else begin
                    r_byte_idx <= r_byte_idx + 4'd1;
                end
            end else if (w_byte_bad || w_timeout) begin
                r_byte_idx <= '0;
            end

            if (w_start_det || w_timeout)
                r_idle_cnt <= '0;
            else if (r_state == S_IDLE && r_byte_idx != 4'd0)
                r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // NOTE: staging storage is not reset; byte_idx guarantees every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (w_byte_good) r_staging[r_byte_idx] <= r_shift;
    end

endmodule
